// File: rtl/pipe_fd_register.sv
// Fetch-to-decode pipeline register with hold/bubble control, valid flag and saturating perf counters.
// One-cycle latency, registered outputs only; stall holds the stage contents even when a bubble is requested.
module pipe_fd_register #(
    parameter int DATA_W    = 64,
    parameter int CODE_W    = 4,
    parameter int REG_W     = 4,
    parameter int STAT_W    = 3,
    parameter int CNT_W     = 16,
    parameter int NOP_ICODE = 1,
    parameter int NONE_REG  = 15,
    parameter int STAT_AOK  = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              f_stall,
    input  logic              f_bubble,
    input  logic              clr_cnt,
    input  logic [CODE_W-1:0] f_icode,
    input  logic [CODE_W-1:0] f_ifun,
    input  logic [REG_W-1:0]  f_regA,
    input  logic [REG_W-1:0]  f_regB,
    input  logic [DATA_W-1:0] f_valC,
    input  logic [DATA_W-1:0] f_valP,
    input  logic [STAT_W-1:0] f_stat,
    output logic [CODE_W-1:0] d_icode,
    output logic [CODE_W-1:0] d_ifun,
    output logic [REG_W-1:0]  d_regA,
    output logic [REG_W-1:0]  d_regB,
    output logic [DATA_W-1:0] d_valC,
    output logic [DATA_W-1:0] d_valP,
    output logic [STAT_W-1:0] d_stat,
    output logic              d_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              conflict
);

    typedef struct packed {
        logic [CODE_W-1:0] icode;
        logic [CODE_W-1:0] ifun;
        logic [REG_W-1:0]  rega;
        logic [REG_W-1:0]  regb;
        logic [DATA_W-1:0] valc;
        logic [DATA_W-1:0] valp;
        logic [STAT_W-1:0] stat;
    } fd_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fd_t  w_nop;
    fd_t  w_fetch;
    fd_t  r_stage;
    logic r_valid;
    logic w_bubble_load;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic r_conflict;

    assign w_nop = '{icode: CODE_W'(NOP_ICODE), ifun: '0,
                     rega: REG_W'(NONE_REG), regb: REG_W'(NONE_REG),
                     valc: '0, valp: '0, stat: STAT_W'(STAT_AOK)};
    assign w_fetch = '{icode: f_icode, ifun: f_ifun, rega: f_regA, regb: f_regB,
                       valc: f_valC, valp: f_valP, stat: f_stat};

    // A bubble only counts when it actually replaces the stage contents.
    assign w_bubble_load = f_bubble && !f_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= w_nop;
            r_valid <= 1'b0;
        end else if (!f_stall) begin
            if (f_bubble) begin
                r_stage <= w_nop;
                r_valid <= 1'b0;
            end else begin
                r_stage <= w_fetch;
                r_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_conflict   <= 1'b0;
        end else if (clr_cnt) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_conflict   <= 1'b0;
        end else begin
            if (f_stall && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_bubble_load && (r_bubble_cnt != CNT_MAX))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            if (f_stall && f_bubble)
                r_conflict <= 1'b1;
        end
    end

    assign d_icode    = r_stage.icode;
    assign d_ifun     = r_stage.ifun;
    assign d_regA     = r_stage.rega;
    assign d_regB     = r_stage.regb;
    assign d_valC     = r_stage.valc;
    assign d_valP     = r_stage.valp;
    assign d_stat     = r_stage.stat;
    assign d_valid    = r_valid;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign conflict   = r_conflict;

endmodule

// File: tb/tb_pipe_fd_register.sv
// Bench for pipe_fd_register (CNT_W=4 so saturation is reachable): directed cases then random traffic vs a reference model.
module tb_pipe_fd_register;

    localparam int CW = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        f_stall = 1'b0, f_bubble = 1'b0, clr_cnt = 1'b0;
    logic [3:0]  f_icode = '0, f_ifun = '0, f_regA = '0, f_regB = '0;
    logic [63:0] f_valC = '0, f_valP = '0;
    logic [2:0]  f_stat = '0;
    logic [3:0]  d_icode, d_ifun, d_regA, d_regB;
    logic [63:0] d_valC, d_valP;
    logic [2:0]  d_stat;
    logic        d_valid, conflict;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the decode stage should hold and what the counters should read.
    int          m_icode, m_ifun, m_rega, m_regb, m_stat, m_valid;
    logic [63:0] m_valc, m_valp;
    int          m_scnt, m_bcnt, m_conf;

    pipe_fd_register #(.CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .f_stall(f_stall), .f_bubble(f_bubble),
        .clr_cnt(clr_cnt), .f_icode(f_icode), .f_ifun(f_ifun), .f_regA(f_regA),
        .f_regB(f_regB), .f_valC(f_valC), .f_valP(f_valP), .f_stat(f_stat),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_regA(d_regA), .d_regB(d_regB),
        .d_valC(d_valC), .d_valP(d_valP), .d_stat(d_stat), .d_valid(d_valid),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .conflict(conflict)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_nop();
        m_icode = 1; m_ifun = 0; m_rega = 15; m_regb = 15;
        m_valc = 0; m_valp = 0; m_stat = 1; m_valid = 0;
    endtask

    task automatic model_reset();
        model_nop();
        m_scnt = 0; m_bcnt = 0; m_conf = 0;
    endtask

    task automatic model_edge();
        int cmax;
        cmax = (1 << CW) - 1;
        if (!f_stall) begin
            if (f_bubble) model_nop();
            else begin
                m_icode = f_icode; m_ifun = f_ifun; m_rega = f_regA; m_regb = f_regB;
                m_valc = f_valC; m_valp = f_valP; m_stat = f_stat; m_valid = 1;
            end
        end
        if (clr_cnt) begin
            m_scnt = 0; m_bcnt = 0; m_conf = 0;
        end else begin
            if (f_stall) m_scnt = (m_scnt < cmax) ? m_scnt + 1 : cmax;
            if (f_bubble && !f_stall) m_bcnt = (m_bcnt < cmax) ? m_bcnt + 1 : cmax;
            if (f_stall && f_bubble) m_conf = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".icode"},  64'(d_icode),    64'(m_icode));
        chk({tag, ".ifun"},   64'(d_ifun),     64'(m_ifun));
        chk({tag, ".regA"},   64'(d_regA),     64'(m_rega));
        chk({tag, ".regB"},   64'(d_regB),     64'(m_regb));
        chk({tag, ".valC"},   d_valC,          m_valc);
        chk({tag, ".valP"},   d_valP,          m_valp);
        chk({tag, ".stat"},   64'(d_stat),     64'(m_stat));
        chk({tag, ".valid"},  64'(d_valid),    64'(m_valid));
        chk({tag, ".scnt"},   64'(stall_cnt),  64'(m_scnt));
        chk({tag, ".bcnt"},   64'(bubble_cnt), 64'(m_bcnt));
        chk({tag, ".conf"},   64'(conflict),   64'(m_conf));
    endtask

    // Called at a falling edge: apply inputs, take one rising edge, compare at the next falling edge.
    task automatic step(input string tag, input logic st, input logic bb, input logic cl,
                        input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                        input logic [2:0] sa);
        f_stall = st; f_bubble = bb; clr_cnt = cl;
        f_icode = ic; f_ifun = fn; f_regA = ra; f_regB = rb;
        f_valC = vc; f_valP = vp; f_stat = sa;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        check_all("reset");
        chk("reset_icode", 64'(d_icode), 64'd1);
        chk("reset_regA", 64'(d_regA), 64'd15);
        chk("reset_valid", 64'(d_valid), 64'd0);
        reset_n = 1'b1;

        step("pass", 0, 0, 0, 4'd3, 4'd0, 4'd15, 4'd2, 64'h10, 64'h0A, 3'd1);
        chk("pass_icode", 64'(d_icode), 64'd3);
        chk("pass_valC", d_valC, 64'h10);
        chk("pass_valid", 64'(d_valid), 64'd1);

        step("load6", 0, 0, 0, 4'd6, 4'd0, 4'd1, 4'd2, 64'h0, 64'h20, 3'd1);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 0, 0, 4'(i + 8), 4'(i), 4'd3, 4'd4, 64'(i * 7 + 1), 64'(i + 99), 3'd2);
        chk("stall_icode", 64'(d_icode), 64'd6);
        chk("stall_valP", d_valP, 64'h20);
        chk("stall_cnt3", 64'(stall_cnt), 64'd3);

        step("bubble", 0, 1, 0, 4'd7, 4'd2, 4'd3, 4'd4, 64'h55, 64'h66, 3'd1);
        chk("bubble_icode", 64'(d_icode), 64'd1);
        chk("bubble_valid", 64'(d_valid), 64'd0);
        chk("bubble_cnt1", 64'(bubble_cnt), 64'd1);
        step("reload", 0, 0, 0, 4'd2, 4'd1, 4'd5, 4'd6, 64'h77, 64'h88, 3'd1);
        chk("reload_icode", 64'(d_icode), 64'd2);

        step("conflict", 1, 1, 0, 4'd9, 4'd9, 4'd9, 4'd9, 64'h99, 64'h99, 3'd4);
        chk("conflict_hold", 64'(d_icode), 64'd2);
        chk("conflict_set", 64'(conflict), 64'd1);
        chk("conflict_scnt", 64'(stall_cnt), 64'd4);
        chk("conflict_bcnt", 64'(bubble_cnt), 64'd1);
        for (int i = 0; i < 3; i++)
            step("sticky", 0, 0, 0, 4'(i), 4'd0, 4'd1, 4'd1, 64'(i), 64'(i), 3'd1);
        chk("conflict_sticky", 64'(conflict), 64'd1);
        step("clr", 0, 0, 1, 4'd4, 4'd0, 4'd1, 4'd1, 64'h1, 64'h2, 3'd1);
        chk("clr_conflict", 64'(conflict), 64'd0);

        for (int i = 0; i < 20; i++)
            step("sat", 1, 0, 0, 4'(i), 4'd0, 4'd0, 4'd0, 64'(i), 64'(i), 3'd0);
        chk("sat_scnt", 64'(stall_cnt), 64'd15);
        step("clr_stall", 1, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 3'd0);
        chk("clr_wins", 64'(stall_cnt), 64'd0);

        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 19) == 0), 4'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom));

        step("load5", 0, 0, 0, 4'd5, 4'd3, 4'd1, 4'd2, 64'h123, 64'h456, 3'd1);
        step("hold5", 1, 0, 0, 4'd8, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 3'd1);
        step("hold5b", 1, 1, 0, 4'd8, 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 3'd1);
        chk("hold5_icode", 64'(d_icode), 64'd5);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_icode", 64'(d_icode), 64'd1);
        chk("async_scnt", 64'(stall_cnt), 64'd0);
        chk("async_conf", 64'(conflict), 64'd0);
        reset_n = 1'b1;
        f_stall = 1'b0; f_bubble = 1'b0;
        @(negedge clock);
        step("post_rst", 0, 0, 0, 4'd11, 4'd1, 4'd2, 4'd3, 64'hABC, 64'hDEF, 3'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
